ram_access_arb: RTL

Two-requester arbiter that shares one dual-port RAM (separate write and read ports, 1-cycle registered read) between requesters A and B. It accepts at most one RAM command per cycle, drives the RAM write or read port from registered outputs, and returns read data to the owning requester. Sits directly in front of the RAM instance, between the RAM and the two traffic sources.

---
 rtl/ram_arb_pkg.sv | 18 +
 rtl/ram_arb_pick.sv | 42 ++++
 rtl/ram_access_arb.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ram_arb_pkg                                                  |
// | Description : Shared types and constants for the two-requester RAM access  |
// |               arbiter (FSM states, grant owner, RAM read latency).         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package ram_arb_pkg;

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} arb_state_t;

  typedef enum logic {OWN_A, OWN_B} arb_owner_t;

  // Cycles between rd_enb and valid data_out on the RAM read port.
  localparam int RAM_RD_LAT = 1;

endpackage
`default_nettype wire

// File: rtl/ram_arb_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ram_arb_pick                                                 |
// | Description : Combinational winner select used when the arbiter is idle.   |
// |               Single request wins outright; contention is resolved by     |
// |               round-robin (RAM_ARB_RR_EN defined) or fixed A priority.     |
// | Revision    : 1.0 - initial release                                        |
// | Macro       : RAM_ARB_RR_EN - enables round-robin on contention            |
// | Ports       : req_a_i, req_b_i  - pending requests                         |
// |               last_grant_i      - owner of most recent grant (RR only)     |
// |               valid_o           - some requester wins this cycle           |
// |               owner_o           - the winning requester                    |
// +----------------------------------------------------------------------------+
module ram_arb_pick
  import ram_arb_pkg::*;
(
  input  logic       req_a_i,
  input  logic       req_b_i,
`ifdef RAM_ARB_RR_EN
  input  arb_owner_t last_grant_i,
`endif
  output logic       valid_o,
  output arb_owner_t owner_o
);

  always_comb begin
    valid_o = req_a_i | req_b_i;
    owner_o = OWN_A;
    if (req_a_i && req_b_i) begin
`ifdef RAM_ARB_RR_EN
      // Whoever was served last yields.
      owner_o = (last_grant_i == OWN_A) ? OWN_B : OWN_A;
`else
      owner_o = OWN_A;
`endif
    end else if (req_b_i) begin
      owner_o = OWN_B;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_access_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ram_access_arb                                               |
// | Description : Shares one dual-port RAM (write port + 1-cycle registered    |
// |               read port) between requesters A and B. One command per      |
// |               cycle, registered RAM command outputs, read data returned   |
// |               to the owning requester via a read tag.                      |
// | Revision    : 1.0 - initial release                                        |
// | Macro       : RAM_ARB_RR_EN - round-robin on contended idle decisions;     |
// |               undefined gives fixed priority to A                          |
// | Ports       : req/we/addr/wdata_{a,b}  - requester commands                |
// |               gnt_{a,b}                - one-cycle grant pulses            |
// |               rvalid/rdata_{a,b}       - read return per requester         |
// |               wr_enb/wr_addr/data_in   - RAM write port                    |
// |               rd_enb/rd_addr/data_out  - RAM read port                     |
// +----------------------------------------------------------------------------+
module ram_access_arb
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic                  gnt_a,
  output logic                  gnt_b,
  output logic                  rvalid_a,
  output logic                  rvalid_b,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic                  wr_enb,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  rd_enb,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] data_out
);

  localparam int TAG_LAST = RAM_RD_LAT - 1;

  arb_state_t            state_q;
  logic                  gnt_a_q, gnt_b_q;
  logic                  wr_enb_q, rd_enb_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q, rd_addr_q;
  logic [DATA_WIDTH-1:0] data_in_q;
  // Read tag pipeline: valid + owner, one stage per cycle of RAM read latency.
  logic [RAM_RD_LAT-1:0] tag_vld_q;
  arb_owner_t            tag_own_q [RAM_RD_LAT];

  logic                  pick_valid;
  arb_owner_t            pick_owner;

  logic                  grant_d;
  arb_owner_t            owner_d;
  logic                  cmd_we_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_d;
  logic [DATA_WIDTH-1:0] cmd_wdata_d;

`ifdef RAM_ARB_RR_EN
  arb_owner_t            last_grant_q;
`endif

  ram_arb_pick u_pick (
    .req_a_i      (req_a),
    .req_b_i      (req_b),
`ifdef RAM_ARB_RR_EN
    .last_grant_i (last_grant_q),
`endif
    .valid_o      (pick_valid),
    .owner_o      (pick_owner)
  );

  // Next grant. From a GRANT state the current owner's req is ignored (it is
  // still the accepted transaction), so the slot goes to the other side.
  always_comb begin
    grant_d = 1'b0;
    owner_d = OWN_A;
    case (state_q)
      IDLE: begin
        grant_d = pick_valid;
        owner_d = pick_owner;
      end
      GRANT_A: begin
        grant_d = req_b;
        owner_d = OWN_B;
      end
      GRANT_B: begin
        grant_d = req_a;
        owner_d = OWN_A;
      end
      default: begin
        grant_d = 1'b0;
        owner_d = OWN_A;
      end
    endcase
  end

  always_comb begin
    cmd_we_d    = (owner_d == OWN_A) ? we_a    : we_b;
    cmd_addr_d  = (owner_d == OWN_A) ? addr_a  : addr_b;
    cmd_wdata_d = (owner_d == OWN_A) ? wdata_a : wdata_b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_a_q   <= 1'b0;
      gnt_b_q   <= 1'b0;
      wr_enb_q  <= 1'b0;
      rd_enb_q  <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      data_in_q <= '0;
      tag_vld_q <= '0;
      for (int i = 0; i < RAM_RD_LAT; i++) tag_own_q[i] <= OWN_A;
`ifdef RAM_ARB_RR_EN
      last_grant_q <= OWN_B;
`endif
    end else begin
      // Tag the read issuing this cycle with its owner (current GRANT state).
      tag_vld_q[0] <= rd_enb_q;
      tag_own_q[0] <= (state_q == GRANT_B) ? OWN_B : OWN_A;
      for (int i = 1; i < RAM_RD_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_own_q[i] <= tag_own_q[i-1];
      end

      gnt_a_q  <= grant_d && (owner_d == OWN_A);
      gnt_b_q  <= grant_d && (owner_d == OWN_B);
      wr_enb_q <= grant_d && cmd_we_d;
      rd_enb_q <= grant_d && !cmd_we_d;

      if (grant_d) begin
        state_q <= (owner_d == OWN_A) ? GRANT_A : GRANT_B;
        // Address/data registers only move when their port is used.
        if (cmd_we_d) begin
          wr_addr_q <= cmd_addr_d;
          data_in_q <= cmd_wdata_d;
        end else begin
          rd_addr_q <= cmd_addr_d;
        end
`ifdef RAM_ARB_RR_EN
        last_grant_q <= owner_d;
`endif
      end else begin
        state_q <= IDLE;
      end
    end
  end

  assign gnt_a    = gnt_a_q;
  assign gnt_b    = gnt_b_q;
  assign wr_enb   = wr_enb_q;
  assign wr_addr  = wr_addr_q;
  assign data_in  = data_in_q;
  assign rd_enb   = rd_enb_q;
  assign rd_addr  = rd_addr_q;
  assign rvalid_a = tag_vld_q[TAG_LAST] && (tag_own_q[TAG_LAST] == OWN_A);
  assign rvalid_b = tag_vld_q[TAG_LAST] && (tag_own_q[TAG_LAST] == OWN_B);
  assign rdata_a  = data_out;
  assign rdata_b  = data_out;

endmodule
`default_nettype wire
